// File: rtl/branch_pkg.sv
// Shared opcodes, BHT counter encodings and the saturating counter update
// for the ID-stage branch resolution unit.
package branch_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    StrongNt = 2'b00,
    WeakNt   = 2'b01,
    WeakT    = 2'b10,
    StrongT  = 2'b11
  } bht_ctr_e;

  function automatic bht_ctr_e sat_update(bht_ctr_e ctr, logic taken);
    bht_ctr_e res;
    res = ctr;
    if (taken) begin
      if (ctr != StrongT) res = bht_ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != StrongNt) res = bht_ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Bimodal branch history table: 2-bit saturating counters with one async read
// port for IF and one synchronous update port for ID.
module branch_bht
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_e         rd_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_e ctr_q [DEPTH];

  // Read returns the pre-update value when rd_idx == wr_idx in the same cycle.
  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= WeakNt;
      end
    end else if (we) begin
      ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage J/BEQ/BNE resolution with bimodal prediction, flush/redirect/stall
// controls and saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned BHT_DEPTH  = 16,
  parameter bit          PREDICT_EN = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  if_pc,
  input  logic                 if_id_write,
  output logic                 if_pred_taken,
  input  logic                 id_valid,
  input  logic [5:0]           id_opcode,
  input  logic [PC_WIDTH-1:0]  id_pc,
  input  logic [WIDTH-1:0]     read_data1,
  input  logic [WIDTH-1:0]     read_data2,
  input  logic                 operands_ready,
  output logic                 zero,
  output logic                 stall,
  output logic                 if_flush,
  output logic                 pc_src,
  output logic                 pc_restore,
  output logic                 jump,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] if_idx, id_idx;
  bht_ctr_e         if_ctr;
  logic             id_pred_q;
  logic             resolve, taken, mispredict;
  logic [CNT_WIDTH-1:0] branch_count_q, mispredict_count_q;
  logic             unused_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign unused_bits = ^{if_pc[PC_WIDTH-1:IDX_W+2], if_pc[1:0],
                         id_pc[PC_WIDTH-1:IDX_W+2], id_pc[1:0], if_ctr[0]};

  branch_bht #(
    .DEPTH(BHT_DEPTH)
  ) u_bht (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (if_idx),
    .rd_ctr  (if_ctr),
    .we      (resolve && PREDICT_EN),
    .wr_idx  (id_idx),
    .wr_taken(taken)
  );

  assign if_pred_taken = PREDICT_EN && !reset && if_ctr[1];
  assign zero          = (read_data1 == read_data2);

  always_comb begin
    stall      = 1'b0;
    if_flush   = 1'b0;
    pc_src     = 1'b0;
    pc_restore = 1'b0;
    jump       = 1'b0;
    resolve    = 1'b0;
    taken      = 1'b0;
    mispredict = 1'b0;
    if (id_valid && !reset) begin
      case (id_opcode)
        OP_J: begin
          jump     = 1'b1;
          if_flush = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          if (!operands_ready) begin
            stall = 1'b1;
          end else begin
            resolve    = 1'b1;
            taken      = (id_opcode == OP_BEQ) ? zero : !zero;
            mispredict = taken ^ id_pred_q;
            pc_src     = taken && mispredict;
            pc_restore = !taken && mispredict;
            if_flush   = mispredict;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pred_q          <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      // A squashed IF slot must not carry its prediction into ID.
      if (if_flush) begin
        id_pred_q <= 1'b0;
      end else if (if_id_write) begin
        id_pred_q <= if_pred_taken;
      end
      if (resolve) begin
        if (branch_count_q != '1) branch_count_q <= branch_count_q + 1'b1;
        if (mispredict && (mispredict_count_q != '1)) begin
          mispredict_count_q <= mispredict_count_q + 1'b1;
        end
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Drives a predicting and a static-not-taken build side by side and checks
// both against a behavioural model of the branch unit.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, if_id_write, id_valid, operands_ready;
  logic [5:0]  id_opcode;
  logic [31:0] if_pc, id_pc, rd1, rd2;

  logic [1:0]  pt, zr, st, fl, ps, pr, jp;
  logic [15:0] bc0, mc0;
  logic [3:0]  bc1, mc1;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .WIDTH(32), .PC_WIDTH(32), .BHT_DEPTH(16), .PREDICT_EN(1'b1), .CNT_WIDTH(16)
  ) u_dut0 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_id_write(if_id_write),
    .if_pred_taken(pt[0]), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .read_data1(rd1), .read_data2(rd2), .operands_ready(operands_ready),
    .zero(zr[0]), .stall(st[0]), .if_flush(fl[0]), .pc_src(ps[0]),
    .pc_restore(pr[0]), .jump(jp[0]), .branch_count(bc0), .mispredict_count(mc0)
  );

  branch_resolve_unit #(
    .WIDTH(32), .PC_WIDTH(32), .BHT_DEPTH(16), .PREDICT_EN(1'b0), .CNT_WIDTH(4)
  ) u_dut1 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_id_write(if_id_write),
    .if_pred_taken(pt[1]), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .read_data1(rd1), .read_data2(rd2), .operands_ready(operands_ready),
    .zero(zr[1]), .stall(st[1]), .if_flush(fl[1]), .pc_src(ps[1]),
    .pc_restore(pr[1]), .jump(jp[1]), .branch_count(bc1), .mispredict_count(mc1)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: counters 0..3 per entry, prediction carried into ID, stats.
  int bht [2][16];
  bit pq  [2];
  int bc  [2];
  int mc  [2];
  int cmax[2] = '{65535, 15};
  bit pe  [2] = '{1'b1, 1'b0};

  task automatic check_eq(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) bht[m][i] = 1;
      pq[m] = 1'b0;
      bc[m] = 0;
      mc[m] = 0;
    end
  endtask

  // Inputs are applied just after a negedge; check 1ns later, then advance.
  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      int  ii, di, gbc, gmc;
      bit  act, isbr, isj, z, e_pred, res, tk, mis, e_flush;
      string p;
      p      = $sformatf("d%0d.", m);
      ii     = int'((if_pc >> 2) % 16);
      di     = int'((id_pc >> 2) % 16);
      act    = id_valid && !reset;
      isbr   = act && (id_opcode == OP_BEQ || id_opcode == OP_BNE);
      isj    = act && (id_opcode == OP_J);
      z      = (rd1 == rd2);
      e_pred = pe[m] && !reset && (bht[m][ii] >= 2);
      res    = isbr && operands_ready;
      tk     = (id_opcode == OP_BEQ) ? z : !z;
      mis    = res && (tk != pq[m]);
      e_flush = isj || mis;
      gbc    = (m == 0) ? int'(bc0) : int'(bc1);
      gmc    = (m == 0) ? int'(mc0) : int'(mc1);

      check_eq({p, "pred"},    int'(pt[m]), int'(e_pred));
      check_eq({p, "zero"},    int'(zr[m]), int'(z));
      check_eq({p, "stall"},   int'(st[m]), int'(isbr && !operands_ready));
      check_eq({p, "flush"},   int'(fl[m]), int'(e_flush));
      check_eq({p, "pc_src"},  int'(ps[m]), int'(mis && tk));
      check_eq({p, "restore"}, int'(pr[m]), int'(mis && !tk));
      check_eq({p, "jump"},    int'(jp[m]), int'(isj));
      check_eq({p, "bcount"},  gbc, bc[m]);
      check_eq({p, "mcount"},  gmc, mc[m]);

      if (reset) begin
        for (int i = 0; i < 16; i++) bht[m][i] = 1;
        pq[m] = 1'b0;
        bc[m] = 0;
        mc[m] = 0;
      end else begin
        if (res) begin
          if (pe[m]) bht[m][di] = tk ? ((bht[m][di] < 3) ? bht[m][di] + 1 : 3)
                                     : ((bht[m][di] > 0) ? bht[m][di] - 1 : 0);
          if (bc[m] < cmax[m]) bc[m] = bc[m] + 1;
          if (mis && mc[m] < cmax[m]) mc[m] = mc[m] + 1;
        end
        if (e_flush) pq[m] = 1'b0;
        else if (if_id_write) pq[m] = e_pred;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(bit rst, bit v, logic [5:0] op, int unsigned ipc, int unsigned a,
                       int unsigned b, bit rdy, int unsigned fpc, bit w);
    reset          = rst;
    id_valid       = v;
    id_opcode      = op;
    id_pc          = ipc;
    rd1            = a;
    rd2            = b;
    operands_ready = rdy;
    if_pc          = fpc;
    if_id_write    = w;
    step();
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_pc = '0; rd1 = '0; rd2 = '0;
    operands_ready = 1'b0; if_pc = '0; if_id_write = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with a ready branch in ID: all controls stay low.
    drive(1, 1, OP_BEQ, 'h40, 5, 5, 1, 'h40, 1);
    // First BEQ predicted not-taken but taken.
    drive(0, 1, OP_BEQ, 'h40, 5, 5, 1, 'h104, 1);
    // Fetch then resolve the same BEQ three times; counter climbs to strong-T.
    repeat (3) begin
      drive(0, 0, 6'b000000, 0, 0, 0, 0, 'h40, 1);
      drive(0, 1, OP_BEQ, 'h40, 5, 5, 1, 'h44, 1);
    end
    // Predicted-taken BNE that is not taken.
    drive(0, 0, 6'b000000, 0, 0, 0, 0, 'h40, 1);
    drive(0, 1, OP_BNE, 'h40, 7, 7, 1, 'h44, 1);
    // Three stall cycles, then resolve.
    drive(0, 0, 6'b000000, 0, 0, 0, 0, 'h80, 1);
    repeat (3) drive(0, 1, OP_BEQ, 'h80, 1, 2, 0, 'h84, 0);
    drive(0, 1, OP_BEQ, 'h80, 1, 2, 1, 'h84, 1);
    // Jump ignores operands_ready; a load opcode is non-control.
    drive(0, 1, OP_J, 'h90, 1, 2, 0, 'h94, 1);
    drive(0, 1, 6'b100011, 'h94, 3, 3, 1, 'h98, 1);
    // Reset arriving while stalled.
    drive(0, 1, OP_BNE, 'hA0, 3, 4, 0, 'hA4, 0);
    drive(1, 1, OP_BNE, 'hA0, 3, 4, 0, 'hA4, 0);
    drive(0, 0, 6'b000000, 0, 0, 0, 0, 'hA4, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [5:0]  op;
      int unsigned r, ipc, fpc, a, b;
      r = $urandom_range(0, 9);
      if (r < 2)      op = OP_J;
      else if (r < 5) op = OP_BEQ;
      else if (r < 8) op = OP_BNE;
      else            op = 6'($urandom);
      ipc = $urandom_range(0, 255) & ~32'd3;
      fpc = ($urandom_range(0, 3) == 0) ? ipc : ($urandom_range(0, 255) & ~32'd3);
      a   = $urandom_range(0, 7);
      b   = ($urandom_range(0, 1) == 1) ? a : $urandom;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), op, ipc, a, b,
            ($urandom_range(0, 3) != 0), fpc, ($urandom_range(0, 4) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
